cpu_mmio_uart: RTL
==================

// Module: cpu_mmio_uart
// PURPOSE
//   Memory-mapped 8N1 UART on the CPU data/instruction bus (mem_addr/mem_wdata/mem_wenable/mem_rdata).
//   Sits downstream of the multi-cycle CPU, alongside RAM. The top level muxes rdata into mem_rdata when hit=1.
//   Has a TX FIFO, a single RX holding register and sticky error flags.
//   The bus has no read strobe, so reads are side-effect free and RX is acknowledged by a write.
// PARAMETERS
//   BASE_ADDR   32'h1000_0000  16-byte aligned base; decode compares mem_addr[31:4] only
//   CLK_DIV     16             clk cycles per UART bit; legal range >= 4
//   FIFO_DEPTH  8              TX FIFO entries; power of two, >= 2
// PORTS
//   clk          in   1   clock, all state on rising edge
//   rst_n        in   1   reset, asynchronous, active-low
//   mem_addr     in   32  CPU bus address
//   mem_wdata    in   32  CPU write data
//   mem_wenable  in   4   byte write enables; 0 = no write
//   rdata        out  32  read data, combinational from mem_addr; 0 when hit=0
//   hit          out  1   mem_addr[31:4] == BASE_ADDR[31:4]
//   uart_tx      out  1   serial out, registered, idle high
//   uart_rx      in   1   serial in, asynchronous to clk
//   irq          out  1   equals rx_valid
// BEHAVIOUR
//   Reset: uart_tx=1, FIFO empty, rx_valid=0, sticky flags=0, both FSMs IDLE.
//   Reset asserted mid-frame forces uart_tx=1 immediately (asynchronous).
//   Register map (offset = mem_addr[3:2]); writes occur only on the edge where hit=1 and the named lane is enabled.
//   0x0 TXDATA: write with wenable[0] pushes wdata[7:0]. Reads return 0.
//     Push while full (full = pre-edge state, even if a pop occurs on the same edge) drops the byte and sets tx_ovf.
//   0x4 RXDATA: read {23'b0, rx_valid, rx_byte}. A write with any lane clears rx_valid.
//   0x8 STATUS: read {25'b0, frame_err, rx_ovr, tx_ovf, rx_valid, tx_busy, tx_full, tx_empty} (bits 6..0).
//     Write with wenable[0]: a 1 in wdata[4]/[5]/[6] clears tx_ovf/rx_ovr/frame_err (W1C).
//   0xC: reads 0; writes are ignored.
//   TX FSM, states IDLE / START / DATA / STOP:
//     Each non-IDLE state holds for CLK_DIV cycles. Bit timing is a counter from CLK_DIV-1 down to 0.
//     DATA shifts 8 bits, LSB first. Bit counter runs 0..7.
//     IDLE with FIFO non-empty: pop into the shift register and go to START. uart_tx falls 1 clk after the push edge.
//     End of STOP with FIFO non-empty: pop and go straight to START, with no idle gap. Otherwise go to IDLE.
//     tx_busy = (state != IDLE).
//     FIFO pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally.
//     full = MSBs differ and the rest are equal; empty = pointers equal.
//   RX FSM, states IDLE / START / DATA / STOP; uart_rx passes through a 2-FF synchronizer first:
//     IDLE: on a synchronized falling edge, go to START and wait CLK_DIV/2 cycles.
//     At mid start bit: if the line is high it was a false start, return to IDLE. Otherwise sample 8 bits, every CLK_DIV cycles, LSB first.
//     At mid stop bit, line = 1: rx_byte <= shifted byte and rx_valid <= 1.
//       If rx_valid was already 1, the byte overwrites and rx_ovr is set.
//     At mid stop bit, line = 0: discard the byte, set frame_err, and go to IDLE.
//     A completed byte and an ack write on the same edge: the byte wins, rx_valid stays 1, no overrun.
//   Status and error flags update in the cycle after their causing edge. A W1C clear and a set on the same edge: the set wins.
// TESTING
//   Reset, then read 0x8 -> 0x0000_0001; uart_tx=1. Read with mem_addr=0x2000_0008 -> hit=0, rdata=0.
//   CLK_DIV=4: write 0xA5 to 0x0 (wenable=0001) -> uart_tx low 1 clk later for 4 clks.
//     Then the bits 1,0,1,0,0,1,0,1 each for 4 clks, then high; frame is 40 clks.
//   9 back-to-back TXDATA writes (DEPTH=8) while TX is idle: the first is popped.
//     The next 8 fill the FIFO with no drop; a 10th write sets STATUS[4] and is not sent.
//   Drive RX frame 0x3C at CLK_DIV=16 -> RXDATA=0x13C, irq=1. Write 0x4 -> RXDATA=0x03C, irq=0.
//   Two RX frames with no ack -> rx_byte = second byte, STATUS[5]=1. Write 0x20 to 0x8 -> STATUS[5]=0.
//   RX frame with stop bit 0 -> rx_valid unchanged, STATUS[6]=1.
//     A 1-clk low glitch on uart_rx -> no byte received, no flags set.

Source files
------------

// File: rtl/cpu_mmio_uart.sv
// Memory-mapped 8N1 UART for the CPU data bus.
// The UART has a TX FIFO, a single RX holding register and sticky error flags.
// Reads have no side effects. RX data is acknowledged by a write.
module cpu_mmio_uart #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wenable,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        uart_tx,
  input  logic        uart_rx,
  output logic        irq
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(CLK_DIV);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLK_DIV / 2 - 1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);
  localparam logic [PtrW:0]   PtrOne   = {{PtrW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uart_state_e;

  // Bus decode
  logic [1:0] offset;
  logic       wr_tx, wr_ack, wr_stat;
  logic       unused_bits;

  assign hit         = (mem_addr[31:4] == BASE_ADDR[31:4]);
  assign offset      = mem_addr[3:2];
  assign wr_tx       = hit && (offset == 2'd0) && mem_wenable[0];
  assign wr_ack      = hit && (offset == 2'd1) && (|mem_wenable);
  assign wr_stat     = hit && (offset == 2'd2) && mem_wenable[0];
  assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:8]};

  // TX FIFO
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PtrW:0] wptr_q, rptr_q;
  logic          fifo_full, fifo_empty, push, pop;

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                      (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  // A full FIFO drops the push, judged on the pre-edge state even if a pop happens on the same edge.
  assign push       = wr_tx && !fifo_full;

  // FIFO storage. It needs no reset because the pointers gate every read.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr_q[PtrW-1:0]] <= mem_wdata[7:0];
  end

  // FIFO pointers. They are one bit wider than the index so that full and empty can be told apart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PtrOne;
      if (pop)  rptr_q <= rptr_q + PtrOne;
    end
  end

  // TX FSM state
  uart_state_e     tx_state_q, tx_state_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic            tx_q, tx_d;

  // TX next state. A new frame's start bit is driven on the same edge that pops the byte.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    pop        = 1'b0;
    unique case (tx_state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          tx_shift_d = fifo_mem[rptr_q[PtrW-1:0]];
          tx_cnt_d   = BitLast;
          tx_d       = 1'b0;
          tx_state_d = StStart;
        end
      end
      StStart: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = StData;
          tx_cnt_d   = BitLast;
          tx_bit_d   = 3'd0;
          tx_d       = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q - CntOne;
        end
      end
      StData: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d = BitLast;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = StStop;
            tx_d       = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_d       = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q - CntOne;
        end
      end
      StStop: begin
        if (tx_cnt_q == '0) begin
          if (!fifo_empty) begin
            // Next byte goes out with no idle gap.
            pop        = 1'b1;
            tx_shift_d = fifo_mem[rptr_q[PtrW-1:0]];
            tx_cnt_d   = BitLast;
            tx_d       = 1'b0;
            tx_state_d = StStart;
          end else begin
            tx_state_d = StIdle;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - CntOne;
        end
      end
      default: tx_state_d = StIdle;
    endcase
  end

  // TX registers. The asynchronous reset forces the line high at once, even in the middle of a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= StIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
    end
  end

  // RX state
  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  uart_state_e     rx_state_q, rx_state_d;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rx_done, rx_ferr;

  // Two-flop synchronizer, plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // RX next state. Every bit is sampled at its midpoint, offset by half a bit from the start edge.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_done    = 1'b0;
    rx_ferr    = 1'b0;
    unique case (rx_state_q)
      StIdle: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = StStart;
          rx_cnt_d   = HalfLast;
        end
      end
      StStart: begin
        if (rx_cnt_q == '0) begin
          if (rx_sync_q) begin
            rx_state_d = StIdle;  // false start
          end else begin
            rx_state_d = StData;
            rx_cnt_d   = BitLast;
            rx_bit_d   = 3'd0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CntOne;
        end
      end
      StData: begin
        if (rx_cnt_q == '0) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_cnt_d   = BitLast;
          if (rx_bit_q == 3'd7) rx_state_d = StStop;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q - CntOne;
        end
      end
      StStop: begin
        if (rx_cnt_q == '0) begin
          rx_state_d = StIdle;
          if (rx_sync_q) rx_done = 1'b1;
          else           rx_ferr = 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q - CntOne;
        end
      end
      default: rx_state_d = StIdle;
    endcase
  end

  // RX FSM registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= StIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // Holding register and sticky flags
  logic [7:0] rx_byte_q;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_ovr_q, rx_ovr_d;
  logic       tx_ovf_q, tx_ovf_d;
  logic       frame_err_q, frame_err_d;

  // Flag next state. On the same edge, a set beats a W1C clear, and a completed byte beats an ack.
  always_comb begin
    rx_valid_d  = rx_valid_q;
    rx_ovr_d    = rx_ovr_q;
    tx_ovf_d    = tx_ovf_q;
    frame_err_d = frame_err_q;
    if (wr_ack)                    rx_valid_d  = 1'b0;
    if (rx_done)                   rx_valid_d  = 1'b1;
    if (wr_stat && mem_wdata[5])   rx_ovr_d    = 1'b0;
    if (rx_done && rx_valid_q && !wr_ack) rx_ovr_d = 1'b1;
    if (wr_stat && mem_wdata[4])   tx_ovf_d    = 1'b0;
    if (wr_tx && fifo_full)        tx_ovf_d    = 1'b1;
    if (wr_stat && mem_wdata[6])   frame_err_d = 1'b0;
    if (rx_ferr)                   frame_err_d = 1'b1;
  end

  // Flag and holding registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_ovr_q    <= 1'b0;
      tx_ovf_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (rx_done) rx_byte_q <= rx_shift_q;
      rx_valid_q  <= rx_valid_d;
      rx_ovr_q    <= rx_ovr_d;
      tx_ovf_q    <= tx_ovf_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Combinational read mux. It returns zero when the address does not hit this block.
  always_comb begin
    rdata = '0;
    if (hit) begin
      case (offset)
        2'd1:    rdata = {23'b0, rx_valid_q, rx_byte_q};
        2'd2:    rdata = {25'b0, frame_err_q, rx_ovr_q, tx_ovf_q, rx_valid_q,
                          (tx_state_q != StIdle), fifo_full, fifo_empty};
        default: rdata = '0;
      endcase
    end
  end

  assign uart_tx = tx_q;
  assign irq     = rx_valid_q;

endmodule
